compare_count_mc: RTL and testbench

Multi-channel, parametrised compare-and-tally block. It replaces the single-channel fixed-width compare counter. Each of NCH lanes compares operand A against operand B at full DATA_W precision, signed or unsigned, and accumulates less-than, equal and greater-than counts. It adds optional saturation with sticky overflow flags, and a coherent snapshot port so host readout never sees a torn count set. It sits beside the loop datapath as a statistics tap, driven by the loop's VALID/LOOP qualifiers.

---
 rtl/compare_count_pkg.sv | 47 ++++
 rtl/compare_count_lane.sv | 88 ++++++++
 rtl/compare_count_mc.sv | 69 ++++++
 tb/tb_compare_count_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_count_pkg.sv
// Shared types and helpers for the multi-channel compare-and-tally block.
// COMPARE_COUNT_SAT_EN selects saturating counters with sticky overflow; otherwise counters wrap.
package compare_count_pkg;

  // Operands are sign/zero-extended to this width before comparison (DATA_W must be below it).
  localparam int unsigned CMP_MAX_W = 512;

  typedef enum logic [1:0] {
    CMP_LT = 2'd0,
    CMP_EQ = 2'd1,
    CMP_GT = 2'd2
  } cmp_code_t;

  typedef struct packed {
    logic inc;      // add one
    logic zero;     // wrap to zero
    logic blocked;  // increment refused at all-ones
  } inc_ctl_t;

  function automatic cmp_code_t cmp3(input logic [CMP_MAX_W-1:0] a,
                                     input logic [CMP_MAX_W-1:0] b,
                                     input logic                 signed_mode);
    cmp_code_t r;
    if (a == b)
      r = CMP_EQ;
    else if (signed_mode ? ($signed(a) < $signed(b)) : (a < b))
      r = CMP_LT;
    else
      r = CMP_GT;
    return r;
  endfunction

  function automatic inc_ctl_t cnt_step(input logic hit, input logic at_max);
    inc_ctl_t r;
`ifdef COMPARE_COUNT_SAT_EN
    r.inc     = hit & ~at_max;
    r.zero    = 1'b0;
    r.blocked = hit & at_max;
`else
    r.inc     = hit & ~at_max;
    r.zero    = hit & at_max;
    r.blocked = 1'b0;
`endif
    return r;
  endfunction

endpackage

// File: rtl/compare_count_lane.sv
// One lane: stage-1 compare, LT/EQ/GT counters, sticky overflow and snapshot shadows.
// Saturation behaviour follows COMPARE_COUNT_SAT_EN through compare_count_pkg::cnt_step.
module compare_count_lane
  import compare_count_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              valid,
  input  logic              loop_r,
  input  logic              clr_r,
  input  logic              snap_r,
  output logic [CNT_W-1:0]  q_lt,
  output logic [CNT_W-1:0]  q_eq,
  output logic [CNT_W-1:0]  q_gt,
  output logic [CNT_W-1:0]  s_lt,
  output logic [CNT_W-1:0]  s_eq,
  output logic [CNT_W-1:0]  s_gt,
  output logic [2:0]        ovf
);

  localparam logic SGN = (SIGNED_CMP != 0);

  logic [CMP_MAX_W-1:0]       a_x, b_x;
  cmp_code_t                  code_r;
  logic                       valid_r;
  logic [2:0][CNT_W-1:0]      q, q_nxt, s;
  logic [2:0]                 ovf_q, ovf_nxt;
  logic                       hit;
  inc_ctl_t                   ctl;

  assign a_x = {{(CMP_MAX_W-DATA_W){SGN & a[DATA_W-1]}}, a};
  assign b_x = {{(CMP_MAX_W-DATA_W){SGN & b[DATA_W-1]}}, b};

  always_comb begin
    q_nxt   = q;
    ovf_nxt = ovf_q;
    ctl     = '0;
    hit     = valid_r & loop_r;
    for (int unsigned i = 0; i < 3; i++) begin
      if (clr_r) begin
        q_nxt[i]    = '0;
        q_nxt[i][0] = hit && (code_r == cmp_code_t'(i));
        ovf_nxt[i]  = 1'b0;
      end else begin
        ctl = cnt_step(hit && (code_r == cmp_code_t'(i)), &q[i]);
        if (ctl.zero)
          q_nxt[i] = '0;
        else if (ctl.inc)
          q_nxt[i] = q[i] + 1'b1;
        if (ctl.blocked)
          ovf_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      code_r  <= CMP_LT;
      valid_r <= 1'b0;
      q       <= '0;
      s       <= '0;
      ovf_q   <= '0;
    end else begin
      code_r  <= cmp3(a_x, b_x, SGN);
      valid_r <= valid;
      q       <= q_nxt;
      ovf_q   <= ovf_nxt;
      // Snapshot takes the values being written this edge, so no torn set.
      if (snap_r)
        s <= q_nxt;
    end
  end

  assign q_lt = q[0];
  assign q_eq = q[1];
  assign q_gt = q[2];
  assign s_lt = s[0];
  assign s_eq = s[1];
  assign s_gt = s[2];
  assign ovf  = ovf_q;

endmodule

// File: rtl/compare_count_mc.sv
// Multi-channel compare-and-tally top: NCH lanes plus the shared control pipeline and SNAP_ACK.
// Define COMPARE_COUNT_SAT_EN for saturating counters with sticky OVF; default wraps.
module compare_count_mc
  import compare_count_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned NCH        = 4,
  parameter int unsigned SIGNED_CMP = 0
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NCH*DATA_W-1:0] A,
  input  logic [NCH*DATA_W-1:0] B,
  input  logic [NCH-1:0]      VALID,
  input  logic                LOOP,
  input  logic                CLR,
  input  logic                SNAP,
  output logic [NCH*CNT_W-1:0] Q0,
  output logic [NCH*CNT_W-1:0] Q1,
  output logic [NCH*CNT_W-1:0] Q2,
  output logic [NCH*CNT_W-1:0] S0,
  output logic [NCH*CNT_W-1:0] S1,
  output logic [NCH*CNT_W-1:0] S2,
  output logic [NCH*3-1:0]    OVF,
  output logic                SNAP_ACK
);

  logic loop_r, clr_r, snap_r;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      loop_r   <= 1'b0;
      clr_r    <= 1'b0;
      snap_r   <= 1'b0;
      SNAP_ACK <= 1'b0;
    end else begin
      loop_r   <= LOOP;
      clr_r    <= CLR;
      snap_r   <= SNAP;
      SNAP_ACK <= snap_r;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    compare_count_lane #(
      .DATA_W    (DATA_W),
      .CNT_W     (CNT_W),
      .SIGNED_CMP(SIGNED_CMP)
    ) u_lane (
      .CLK   (CLK),
      .RST_N (RST_N),
      .a     (A[c*DATA_W +: DATA_W]),
      .b     (B[c*DATA_W +: DATA_W]),
      .valid (VALID[c]),
      .loop_r(loop_r),
      .clr_r (clr_r),
      .snap_r(snap_r),
      .q_lt  (Q0[c*CNT_W +: CNT_W]),
      .q_eq  (Q1[c*CNT_W +: CNT_W]),
      .q_gt  (Q2[c*CNT_W +: CNT_W]),
      .s_lt  (S0[c*CNT_W +: CNT_W]),
      .s_eq  (S1[c*CNT_W +: CNT_W]),
      .s_gt  (S2[c*CNT_W +: CNT_W]),
      .ovf   (OVF[c*3 +: 3])
    );
  end

endmodule

// File: tb/tb_compare_count_mc.sv
// Scoreboard bench for compare_count_mc: 4-lane unsigned, 1-lane signed and 1-lane CNT_W=4 instances.
// Expectations follow COMPARE_COUNT_SAT_EN when the bench is built with it.
module tb_compare_count_mc;

  localparam int NCH = 4;
  localparam int DW  = 64;

  typedef struct packed {
    logic [3:0][2:0][31:0] q;
    logic [3:0][2:0][31:0] s;
    logic [3:0][2:0]       ovf;
    logic                  ack;
  } dstate_t;

  typedef struct packed {
    dstate_t m;
    dstate_t g;
    dstate_t t;
  } exp_t;

  logic CLK = 1'b0;
  logic RST_N = 1'b1;
  logic [NCH*DW-1:0] A = '0, B = '0;
  logic [NCH-1:0] VALID = '0;
  logic LOOP = 1'b0, CLR = 1'b0, SNAP = 1'b0;

  logic [127:0] m_q0, m_q1, m_q2, m_s0, m_s1, m_s2;
  logic [11:0]  m_ovf;
  logic         m_ack;
  logic [31:0]  g_q0, g_q1, g_q2, g_s0, g_s1, g_s2;
  logic [2:0]   g_ovf;
  logic         g_ack;
  logic [3:0]   t_q0, t_q1, t_q2, t_s0, t_s1, t_s2;
  logic [2:0]   t_ovf;
  logic         t_ack;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  dstate_t mm, mg, mt;

  always #5 CLK = ~CLK;

  compare_count_mc #(.DATA_W(64), .CNT_W(32), .NCH(4), .SIGNED_CMP(0)) u_main (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .VALID(VALID), .LOOP(LOOP), .CLR(CLR), .SNAP(SNAP),
    .Q0(m_q0), .Q1(m_q1), .Q2(m_q2), .S0(m_s0), .S1(m_s1), .S2(m_s2), .OVF(m_ovf), .SNAP_ACK(m_ack));

  compare_count_mc #(.DATA_W(64), .CNT_W(32), .NCH(1), .SIGNED_CMP(1)) u_sgn (
    .CLK(CLK), .RST_N(RST_N), .A(A[63:0]), .B(B[63:0]), .VALID(VALID[0]), .LOOP(LOOP), .CLR(CLR), .SNAP(SNAP),
    .Q0(g_q0), .Q1(g_q1), .Q2(g_q2), .S0(g_s0), .S1(g_s1), .S2(g_s2), .OVF(g_ovf), .SNAP_ACK(g_ack));

  compare_count_mc #(.DATA_W(64), .CNT_W(4), .NCH(1), .SIGNED_CMP(0)) u_sat (
    .CLK(CLK), .RST_N(RST_N), .A(A[63:0]), .B(B[63:0]), .VALID(VALID[0]), .LOOP(LOOP), .CLR(CLR), .SNAP(SNAP),
    .Q0(t_q0), .Q1(t_q1), .Q2(t_q2), .S0(t_s0), .S1(t_s1), .S2(t_s2), .OVF(t_ovf), .SNAP_ACK(t_ack));

  function automatic dstate_t mdl(input dstate_t st, input int nl, input int w, input bit sgn,
                                  input logic [NCH*DW-1:0] a, input logic [NCH*DW-1:0] b,
                                  input logic [NCH-1:0] v, input logic loop, input logic clr,
                                  input logic snap);
    dstate_t r;
    logic [31:0] maxv;
    logic [63:0] aa, bb;
    int k;
    logic hit;
    r = st;
    maxv = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    for (int c = 0; c < nl; c++) begin
      aa = a[c*DW +: DW];
      bb = b[c*DW +: DW];
      if (aa == bb) k = 1;
      else if (sgn ? ($signed(aa) < $signed(bb)) : (aa < bb)) k = 0;
      else k = 2;
      hit = v[c] & loop;
      if (clr) begin
        r.q[c] = '0;
        r.ovf[c] = '0;
        if (hit) r.q[c][k] = 32'd1;
      end else if (hit) begin
        if (r.q[c][k] == maxv) begin
`ifdef COMPARE_COUNT_SAT_EN
          r.ovf[c][k] = 1'b1;
`else
          r.q[c][k] = '0;
`endif
        end else begin
          r.q[c][k] = r.q[c][k] + 32'd1;
        end
      end
    end
    if (snap) r.s = r.q;
    r.ack = snap;
    return r;
  endfunction

  // sel 0..2 selects Q0..Q2, 3..5 selects S0..S2, packed as the DUT does
  function automatic logic [127:0] pk(input dstate_t st, input int sel, input int nl, input int w);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < nl; c++)
      for (int j = 0; j < w; j++)
        r[c*w + j] = (sel < 3) ? st.q[c][sel][j] : st.s[c][sel-3][j];
    return r;
  endfunction

  function automatic logic [127:0] pko(input dstate_t st, input int nl);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < nl; c++)
      for (int j = 0; j < 3; j++)
        r[c*3 + j] = st.ovf[c][j];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk("main_q0", m_q0, pk(e.m, 0, 4, 32));
    chk("main_q1", m_q1, pk(e.m, 1, 4, 32));
    chk("main_q2", m_q2, pk(e.m, 2, 4, 32));
    chk("main_s0", m_s0, pk(e.m, 3, 4, 32));
    chk("main_s1", m_s1, pk(e.m, 4, 4, 32));
    chk("main_s2", m_s2, pk(e.m, 5, 4, 32));
    chk("main_ovf", m_ovf, pko(e.m, 4));
    chk("main_ack", m_ack, e.m.ack);
    chk("sgn_q0", g_q0, pk(e.g, 0, 1, 32));
    chk("sgn_q1", g_q1, pk(e.g, 1, 1, 32));
    chk("sgn_q2", g_q2, pk(e.g, 2, 1, 32));
    chk("sgn_s0", g_s0, pk(e.g, 3, 1, 32));
    chk("sgn_s1", g_s1, pk(e.g, 4, 1, 32));
    chk("sgn_s2", g_s2, pk(e.g, 5, 1, 32));
    chk("sgn_ovf", g_ovf, pko(e.g, 1));
    chk("sgn_ack", g_ack, e.g.ack);
    chk("sat_q0", t_q0, pk(e.t, 0, 1, 4));
    chk("sat_q1", t_q1, pk(e.t, 1, 1, 4));
    chk("sat_q2", t_q2, pk(e.t, 2, 1, 4));
    chk("sat_s0", t_s0, pk(e.t, 3, 1, 4));
    chk("sat_s1", t_s1, pk(e.t, 4, 1, 4));
    chk("sat_s2", t_s2, pk(e.t, 5, 1, 4));
    chk("sat_ovf", t_ovf, pko(e.t, 1));
    chk("sat_ack", t_ack, e.t.ack);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_m_q0"}, m_q0, '0);  chk({tag, "_m_q1"}, m_q1, '0);  chk({tag, "_m_q2"}, m_q2, '0);
    chk({tag, "_m_s0"}, m_s0, '0);  chk({tag, "_m_s1"}, m_s1, '0);  chk({tag, "_m_s2"}, m_s2, '0);
    chk({tag, "_m_ovf"}, m_ovf, '0); chk({tag, "_m_ack"}, m_ack, '0);
    chk({tag, "_g_q"}, {g_q0, g_q1, g_q2}, '0); chk({tag, "_g_s"}, {g_s0, g_s1, g_s2}, '0);
    chk({tag, "_g_misc"}, {g_ovf, g_ack}, '0);
    chk({tag, "_t_q"}, {t_q0, t_q1, t_q2}, '0); chk({tag, "_t_s"}, {t_s0, t_s1, t_s2}, '0);
    chk({tag, "_t_misc"}, {t_ovf, t_ack}, '0);
  endtask

  task automatic model_reset();
    mm = '0;
    mg = '0;
    mt = '0;
    sb.delete();
  endtask

  task automatic step(input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] v,
                      input logic loop, input logic clr, input logic snap);
    exp_t e;
    A[63:0] = a0;
    B[63:0] = b0;
    for (int c = 1; c < NCH; c++) begin
      A[c*DW +: DW] = 64'($urandom_range(0, 3));
      B[c*DW +: DW] = 64'($urandom_range(0, 3));
    end
    VALID = v;
    LOOP  = loop;
    CLR   = clr;
    SNAP  = snap;
    mm = mdl(mm, 4, 32, 1'b0, A, B, VALID, LOOP, CLR, SNAP);
    mg = mdl(mg, 1, 32, 1'b1, A, B, VALID, LOOP, CLR, SNAP);
    mt = mdl(mt, 1, 4, 1'b0, A, B, VALID, LOOP, CLR, SNAP);
    e.m = mm;
    e.g = mg;
    e.t = mt;
    sb.push_back(e);
    @(posedge CLK);
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check_all(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(64'd0, 64'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #1 RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1 check_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // GT, EQ, LT on lane 0 only
    step(64'd5, 64'd3, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(64'd3, 64'd3, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(64'd2, 64'd3, 4'b0001, 1'b1, 1'b0, 1'b0);
    idle(2);

    // signed vs unsigned view of all-ones, and a high-half-only difference
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(64'h0000_0001_0000_0000, 64'd0, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0001, 1'b1, 1'b0, 1'b0);
    idle(2);

    // clear, EQ run with a snapshot on the 3rd sample, then the clear variants
    step(64'd0, 64'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      step(64'd7, 64'd7, 4'b0001, 1'b1, 1'b0, (i == 2));
    step(64'd1, 64'd2, 4'b0001, 1'b1, 1'b1, 1'b0);
    idle(2);
    step(64'd1, 64'd2, 4'b0001, 1'b1, 1'b1, 1'b0);
    step(64'd3, 64'd3, 4'b0001, 1'b1, 1'b1, 1'b0);
    step(64'd3, 64'd3, 4'b0000, 1'b1, 1'b1, 1'b0);
    step(64'd9, 64'd2, 4'b0001, 1'b0, 1'b0, 1'b0);
    step(64'd4, 64'd4, 4'b0001, 1'b1, 1'b1, 1'b1);
    idle(2);

    // 17 GT samples into the 4-bit counter, then clear
    step(64'd0, 64'd0, 4'b0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++)
      step(64'd9, 64'd1, 4'b0001, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(64'd0, 64'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    idle(2);

    // back-to-back snapshots while counting
    step(64'd1, 64'd1, 4'b1111, 1'b1, 1'b0, 1'b1);
    step(64'd2, 64'd1, 4'b1111, 1'b1, 1'b0, 1'b1);
    step(64'd1, 64'd2, 4'b1111, 1'b1, 1'b0, 1'b0);
    idle(2);

    // mixed traffic on all lanes
    for (int i = 0; i < 40; i++)
      step($urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 3)),
           $urandom_range(0, 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 3)),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0));
    idle(2);

    // reset with samples and a snapshot in flight
    step(64'd5, 64'd3, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(64'd3, 64'd3, 4'b1111, 1'b1, 1'b0, 1'b1);
    #2 RST_N = 1'b0;
    #1 check_zero("midrst");
    model_reset();
    @(posedge CLK);
    #1 check_zero("midrst_hold");
    @(negedge CLK);
    RST_N = 1'b1;
    step(64'd2, 64'd3, 4'b0001, 1'b1, 1'b0, 1'b0);
    step(64'd3, 64'd3, 4'b0001, 1'b1, 1'b0, 1'b1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
